lp805x_lfsr_rng: RTL
====================

// Module: lp805x_lfsr_rng
// PURPOSE
//  SFR-mapped pseudo-random byte generator for the lp805x core, successor to the fixed 32-bit RNG.
//  Galois LFSR with parametrised width and software-programmable tap polynomial.
//  A byte FIFO is refilled in the background, so RNGOUT reads never wait on generation.
//  Sits on the SFR bus beside the other lp805x peripherals; byte access only, no bit-addressable SFRs.
// PARAMETERS
//  WIDTH        32            LFSR width in bits; multiple of 8, 8..64
//  FIFO_DEPTH   4             output byte FIFO depth, 2..15
//  RST_POLY     32'h80200003  tap mask after reset (WIDTH bits)
//  RST_SEED     32'h00000001  LFSR state after reset (WIDTH bits, nonzero)
//  ADDR_CON     8'hfc         RNGCON SFR address
//  ADDR_DAT     8'hfd         RNGDAT SFR address
//  ADDR_OUT     8'hfe         RNGOUT SFR address
//  ADDR_STA     8'hfb         RNGSTA SFR address
// PORTS
//  clk       in   1  clock; the only clock
//  rst       in   1  synchronous active-high reset
//  wr_addr   in   8  SFR write address
//  rd_addr   in   8  SFR read address
//  data_in   in   8  SFR write data
//  wr        in   1  write strobe
//  rd        in   1  read strobe
//  wr_bit    in   1  bit-addressed write; when 1 the write is ignored
//  rd_bit    in   1  bit-addressed read; unused
//  bit_in    in   1  unused
//  data_out  out  8  registered read data; 8'hzz when not driving
//  bit_out   out  1  constant 1'bz
// BEHAVIOUR
//  Byte write = wr & ~wr_bit. Reset: RNGCON=0, ptr=0, staging=0, state=RST_SEED, poly=RST_POLY,
//    FIFO empty, UNDF=0, bitcnt=0, data_out=z.
//  RNGCON bits:
//    [7] EN.
//    [6] LOAD: self-clearing, reads 0. Copies staging seed to state (an all-zero seed loads 1),
//        flushes FIFO, zeroes bitcnt.
//    [5] FREE: free-run mode.
//    [4] PTRCLR: self-clearing, reads 0. Sets ptr to 0.
//    [3] SEL: RNGDAT target; 0 = seed staging, 1 = poly.
//    [2:0] reserved, read 0.
//  RNGDAT write: byte ptr of the target (SEL=0 seed staging, SEL=1 poly) <= data_in;
//    ptr <= ptr+1, wrapping from WIDTH/8-1 to 0. Poly bytes take effect on the next step.
//  Step (Galois): s <= (s>>1) ^ (s[0] ? poly : 0); bitcnt <= bitcnt+1 mod 8.
//    When bitcnt is 7, the new state's s[7:0] is pushed to the FIFO.
//  Stepping rules:
//    EN=0 -> no step.
//    EN=1, FREE=0 -> step only if the FIFO will not be full after this cycle's pop (demand mode).
//    EN=1, FREE=1 -> step every cycle; a push to a full FIFO with no pop is dropped.
//    Cycle of a LOAD write -> no step; stepping resumes the next cycle.
//  RNGOUT read in cycle N (rd & rd_addr==ADDR_OUT):
//    Pops the head; data_out = head in cycle N+1.
//    If the FIFO is empty: data_out=8'h00, UNDF<=1, no pop.
//  Push and pop in the same cycle: both occur, count unchanged. A push on full is accepted when a pop occurs.
//  RNGSTA (read-only): [7] FULL, [6] EMPTY, [5] UNDF (sticky), [4] 0, [3:0] count.
//    Any byte write to ADDR_STA clears UNDF.
//  RNGCON read returns {EN,0,FREE,0,SEL,3'b0}. RNGDAT reads 8'h00.
//  data_out: registered, valid the cycle after rd to one of the 4 addresses; other addresses/cycles -> 8'hzz.
//  Latency: after a LOAD write with EN=1, EMPTY reads 0 nine cycles later (8 steps + push).
//  Reset mid-generation discards the FIFO and partial bitcnt immediately.
// TESTING
//  Use WIDTH=8, FIFO_DEPTH=4.
//  1. SEL=1, write DAT=8'hB8; SEL=0, DAT=8'h01; write CON=8'hC0 (EN,LOAD); wait 9 cycles
//     -> RNGSTA EMPTY=0, count=1; RNGOUT read returns 8'h64.
//  2. Demand mode, no reads for 60 cycles -> count=4, FULL=1, state frozen;
//     4 reads return 4 distinct bytes, then EMPTY=1.
//  3. Read RNGOUT with the FIFO empty -> data_out=8'h00, UNDF=1;
//     write RNGSTA -> UNDF=0.
//  4. FIFO full, then 8 consecutive pop reads with FREE=1 -> after 8 more cycles count=1
//     and no byte loss beyond the documented drop-on-full.
//  5. Load an all-zero seed -> state becomes 1; the sequence matches scenario 1.
//  6. WIDTH=32: with ptr at 3, write DAT twice -> ptr wraps to 0 (second byte lands in bits [7:0]);
//     assert rst mid-run -> all registers return to reset values next cycle.

Source files
------------

// File: rtl/lp805x_lfsr_rng.sv
// rtl/lp805x_lfsr_rng.sv - SFR-mapped Galois LFSR random byte generator with background-filled byte FIFO
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   wr_addr   SFR write address
//   rd_addr   SFR read address
//   data_in   SFR write data
//   wr        write strobe
//   rd        read strobe
//   wr_bit    bit-addressed write (such writes are ignored)
//   rd_bit    bit-addressed read (unused)
//   bit_in    bit write data (unused)
//   data_out  registered read data, high-impedance when not driving
//   bit_out   constant high-impedance
//
// SFRs: RNGCON {EN,LOAD,FREE,PTRCLR,SEL,3'b0}, RNGDAT (seed/poly byte port),
//       RNGOUT (FIFO pop), RNGSTA {FULL,EMPTY,UNDF,0,count[3:0]}

module lp805x_lfsr_rng #(
   parameter int               WIDTH      = 32,
   parameter int               FIFO_DEPTH = 4,
   parameter logic [WIDTH-1:0] RST_POLY   = 32'h80200003,
   parameter logic [WIDTH-1:0] RST_SEED   = 32'h00000001,
   parameter logic [7:0]       ADDR_CON   = 8'hfc,
   parameter logic [7:0]       ADDR_DAT   = 8'hfd,
   parameter logic [7:0]       ADDR_OUT   = 8'hfe,
   parameter logic [7:0]       ADDR_STA   = 8'hfb
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] wr_addr,
   input  logic [7:0] rd_addr,
   input  logic [7:0] data_in,
   input  logic       wr,
   input  logic       rd,
   input  logic       wr_bit,
   input  logic       rd_bit,
   input  logic       bit_in,
   output wire  [7:0] data_out,
   output wire        bit_out
);

   localparam int NB = WIDTH / 8;
   localparam int PW = (NB > 1) ? $clog2(NB) : 1;
   localparam int IW = $clog2(FIFO_DEPTH);
   localparam logic [PW-1:0] PTR_LAST  = PW'(NB - 1);
   localparam logic [IW-1:0] FIFO_LAST = IW'(FIFO_DEPTH - 1);
   localparam logic [3:0]    DEPTH_C   = 4'(FIFO_DEPTH);

   logic             en, free, sel;
   logic [PW-1:0]    ptr;
   logic [WIDTH-1:0] seed, poly, state;
   logic [2:0]       bitcnt;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [IW-1:0]    head, tail;
   logic [3:0]       count;
   logic             undf;
   logic [7:0]       dout_q;
   logic             dout_en;

   logic             byte_wr, wr_con, wr_dat, wr_sta, rd_out, rd_hit;
   logic             empty, full, pop, load, step, push, push_ok;
   logic [3:0]       count_after_pop;
   logic [WIDTH-1:0] next_state;

   logic unused_in;
   assign unused_in = rd_bit ^ bit_in;

   function automatic logic [IW-1:0] fifo_inc(input logic [IW-1:0] p);
      return (p == FIFO_LAST) ? '0 : p + IW'(1);
   endfunction

   always_comb begin
      byte_wr         = wr & ~wr_bit;
      wr_con          = byte_wr && (wr_addr == ADDR_CON);
      wr_dat          = byte_wr && (wr_addr == ADDR_DAT);
      wr_sta          = byte_wr && (wr_addr == ADDR_STA);
      rd_out          = rd && (rd_addr == ADDR_OUT);
      rd_hit          = rd && ((rd_addr == ADDR_CON) || (rd_addr == ADDR_DAT) ||
                               (rd_addr == ADDR_OUT) || (rd_addr == ADDR_STA));
      empty           = (count == 4'd0);
      full            = (count == DEPTH_C);
      pop             = rd_out && !empty;
      load            = wr_con && data_in[6];
      count_after_pop = count - {3'b000, pop};
      // Demand mode holds the LFSR once the FIFO would stay full; free-run never holds.
      step            = en && !load && (free || (count_after_pop != DEPTH_C));
      next_state      = (state >> 1) ^ (state[0] ? poly : '0);
      push            = step && (bitcnt == 3'd7);
      // A push into a full FIFO only lands if a pop frees a slot this cycle.
      push_ok         = push && (count_after_pop != DEPTH_C);
   end

   always_ff @(posedge clk) begin
      if (!rst && !load && push_ok) begin
         fifo_mem[tail] <= next_state[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en      <= 1'b0;
         free    <= 1'b0;
         sel     <= 1'b0;
         ptr     <= '0;
         seed    <= '0;
         poly    <= RST_POLY;
         state   <= RST_SEED;
         bitcnt  <= 3'd0;
         head    <= '0;
         tail    <= '0;
         count   <= 4'd0;
         undf    <= 1'b0;
         dout_q  <= 8'h00;
         dout_en <= 1'b0;
      end else begin
         if (wr_con) begin
            en   <= data_in[7];
            free <= data_in[5];
            sel  <= data_in[3];
            if (data_in[4]) begin
               ptr <= '0;
            end
         end

         if (wr_dat) begin
            for (int i = 0; i < NB; i++) begin
               if (ptr == PW'(i)) begin
                  if (sel) begin
                     poly[i*8 +: 8] <= data_in;
                  end else begin
                     seed[i*8 +: 8] <= data_in;
                  end
               end
            end
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
         end

         if (load) begin
            // An all-zero state would lock the LFSR, so it is replaced by 1.
            state  <= (seed == '0) ? WIDTH'(1) : seed;
            bitcnt <= 3'd0;
            head   <= '0;
            tail   <= '0;
            count  <= 4'd0;
         end else begin
            if (step) begin
               state  <= next_state;
               bitcnt <= bitcnt + 3'd1;
            end
            if (pop) begin
               head <= fifo_inc(head);
            end
            if (push_ok) begin
               tail <= fifo_inc(tail);
            end
            count <= count_after_pop + {3'b000, push_ok};
         end

         // Underflow set wins over a same-cycle clear.
         if (wr_sta) begin
            undf <= 1'b0;
         end
         if (rd_out && empty) begin
            undf <= 1'b1;
         end

         dout_en <= rd_hit;
         if (rd) begin
            if (rd_addr == ADDR_OUT) begin
               dout_q <= empty ? 8'h00 : fifo_mem[head];
            end else if (rd_addr == ADDR_CON) begin
               dout_q <= {en, 1'b0, free, 1'b0, sel, 3'b000};
            end else if (rd_addr == ADDR_STA) begin
               dout_q <= {full, empty, undf, 1'b0, count};
            end else begin
               dout_q <= 8'h00;
            end
         end
      end
   end

   assign data_out = dout_en ? dout_q : 8'hzz;
   assign bit_out  = 1'bz;

endmodule
